// File: rtl/window_feeder_pkg.sv
// Shared constants, FSM state type and configuration check for the window feeder.
package window_feeder_pkg;

  localparam int unsigned KERNEL_MAX_DEFAULT = 7;
  localparam int unsigned PIX_W              = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_LAUNCH,
    ST_WAIT
  } state_t;

  // A frame is accepted only for an odd, non-zero kernel that fits the image
  // and the image fits the line buffers.
  function automatic logic cfg_ok(input int unsigned k, input int unsigned w,
                                  input int unsigned h, input int unsigned max_k,
                                  input int unsigned max_w, input int unsigned max_h);
    return (k != 0) && (k % 2 == 1) && (k <= max_k) && (k <= w) && (k <= h) &&
           (w != 0) && (h != 0) && (w <= max_w) && (h <= max_h);
  endfunction

endpackage

// File: rtl/window_feeder_if.sv
// Frame configuration, pixel stream, compute engine and result stream signals.
interface window_feeder_if
  import window_feeder_pkg::*;
#(
  parameter int unsigned MAX_KERNEL = KERNEL_MAX_DEFAULT,
  parameter int unsigned MAX_WIDTH  = 64,
  parameter int unsigned MAX_HEIGHT = 64
);

  logic                                        frame_start;
  logic [$clog2(MAX_KERNEL)-1:0]               kernel_size;
  logic [$clog2(MAX_WIDTH+1)-1:0]              img_width;
  logic [$clog2(MAX_HEIGHT+1)-1:0]             img_height;

  logic                                        pix_valid;
  logic                                        pix_ready;
  logic [PIX_W-1:0]                            pix_data;

  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] input_matrix;
  logic                                        compute_start;
  logic                                        compute_done;
  logic [PIX_W-1:0]                            blurred_pixel;

  logic                                        res_valid;
  logic [PIX_W-1:0]                            res_data;
  logic [$clog2(MAX_WIDTH)-1:0]                res_x;
  logic [$clog2(MAX_HEIGHT)-1:0]               res_y;
  logic                                        frame_done;
  logic                                        err;

  // Feeder side
  modport master (
    input  frame_start, kernel_size, img_width, img_height,
    input  pix_valid, pix_data, compute_done, blurred_pixel,
    output pix_ready, input_matrix, compute_start,
    output res_valid, res_data, res_x, res_y, frame_done, err
  );

  // Source, compute engine and result sink side
  modport slave (
    output frame_start, kernel_size, img_width, img_height,
    output pix_valid, pix_data, compute_done, blurred_pixel,
    input  pix_ready, input_matrix, compute_start,
    input  res_valid, res_data, res_x, res_y, frame_done, err
  );

endinterface

// File: rtl/window_feeder_line_buffer.sv
// Column-shifting line store: writing column x pushes every row one line older.
module window_feeder_line_buffer
  import window_feeder_pkg::*;
#(
  parameter int unsigned ROWS  = KERNEL_MAX_DEFAULT - 1,
  parameter int unsigned DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH)-1:0]       wx,
  input  logic [PIX_W-1:0]               wdata,
  output logic [ROWS-1:0][PIX_W-1:0]     col
);

  // mem[0] holds the previous line, mem[ROWS-1] the oldest one
  logic [PIX_W-1:0] mem [ROWS][DEPTH];

  // Shift column wx down one line and insert the new pixel on top
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0][wx] <= wdata;
      for (int unsigned i = 1; i < ROWS; i++) begin
        mem[i][wx] <= mem[i-1][wx];
      end
    end
  end

  // Older pixels of the column currently being written
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      col[i] = mem[i][wx];
    end
  end

endmodule

// File: rtl/window_feeder.sv
// Streams raster pixels into a sliding KxK window and hands each interior
// window to the compute engine through a start/done handshake.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int unsigned MAX_KERNEL = KERNEL_MAX_DEFAULT,
  parameter int unsigned MAX_WIDTH  = 64,
  parameter int unsigned MAX_HEIGHT = 64
) (
  input  logic           clk,
  input  logic           rst,
  window_feeder_if.master bus
);

  localparam int unsigned KW = $clog2(MAX_KERNEL);
  localparam int unsigned WW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned HW = $clog2(MAX_HEIGHT + 1);
  localparam int unsigned XW = $clog2(MAX_WIDTH);
  localparam int unsigned YW = $clog2(MAX_HEIGHT);

  state_t                                            state;
  logic [KW-1:0]                                     k;
  logic [WW-1:0]                                     w;
  logic [HW-1:0]                                     h;
  logic [XW-1:0]                                     x;
  logic [XW-1:0]                                     lx;
  logic [YW-1:0]                                     y;
  logic [YW-1:0]                                     ly;
  logic                                              last;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0]  win;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0]  next_win;
  logic [MAX_KERNEL-1:0][PIX_W-1:0]                  new_col;
  logic [MAX_KERNEL-2:0][PIX_W-1:0]                  lb_col;
  logic [31:0]                                       kk;
  logic                                              accept;
  logic                                              cfg_valid;
  logic                                              x_last;
  logic                                              y_last;
  logic                                              in_window;

  assign kk        = 32'(k);
  assign accept    = bus.pix_valid && bus.pix_ready;
  assign cfg_valid = cfg_ok(32'(bus.kernel_size), 32'(bus.img_width), 32'(bus.img_height),
                            MAX_KERNEL, MAX_WIDTH, MAX_HEIGHT);
  assign x_last    = (WW'(x) == w - WW'(1));
  assign y_last    = (HW'(y) == h - HW'(1));
  assign in_window = (WW'(x) >= WW'(k) - WW'(1)) && (HW'(y) >= HW'(k) - HW'(1));

  assign bus.input_matrix = win;

  window_feeder_line_buffer #(
    .ROWS  (MAX_KERNEL - 1),
    .DEPTH (MAX_WIDTH)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .wx    (x),
    .wdata (bus.pix_data),
    .col   (lb_col)
  );

  // Newest window column: rows above the bottom come from the line store,
  // row K-1 is the incoming pixel, rows at or beyond K stay zero
  always_comb begin
    for (int unsigned r = 0; r < MAX_KERNEL; r++) begin
      new_col[r] = '0;
      if (r + 1 == kk) begin
        new_col[r] = bus.pix_data;
      end else begin
        for (int unsigned j = 0; j < MAX_KERNEL - 1; j++) begin
          if (r + j + 2 == kk) new_col[r] = lb_col[j];
        end
      end
    end
  end

  // Window after an accept: every row shifts toward column 0, column K-1
  // takes the new column, anything outside KxK is forced to zero
  always_comb begin
    next_win = '0;
    for (int unsigned r = 0; r < MAX_KERNEL; r++) begin
      next_win[r] = win[r] >> PIX_W;
      for (int unsigned c = 0; c < MAX_KERNEL; c++) begin
        if (r >= kk || c >= kk) begin
          next_win[r][c] = '0;
        end else if (c + 1 == kk) begin
          next_win[r][c] = new_col[r];
        end
      end
    end
  end

  // Frame control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      k                 <= '0;
      w                 <= '0;
      h                 <= '0;
      x                 <= '0;
      y                 <= '0;
      lx                <= '0;
      ly                <= '0;
      last              <= 1'b0;
      win               <= '0;
      bus.pix_ready     <= 1'b0;
      bus.compute_start <= 1'b0;
      bus.res_valid     <= 1'b0;
      bus.res_data      <= '0;
      bus.res_x         <= '0;
      bus.res_y         <= '0;
      bus.frame_done    <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      bus.compute_start <= 1'b0;
      bus.res_valid     <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.err           <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.frame_start) begin
            if (cfg_valid) begin
              k             <= bus.kernel_size;
              w             <= bus.img_width;
              h             <= bus.img_height;
              x             <= '0;
              y             <= '0;
              win           <= '0;
              bus.pix_ready <= 1'b1;
              state         <= ST_FILL;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (accept) begin
            win <= next_win;
            if (x_last) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            // The x >= K-1 test keeps windows that straddle a row wrap from launching
            if (in_window) begin
              lx                <= x;
              ly                <= y;
              last              <= x_last && y_last;
              bus.pix_ready     <= 1'b0;
              bus.compute_start <= 1'b1;
              state             <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.compute_done) begin
            bus.res_data  <= bus.blurred_pixel;
            bus.res_x     <= lx - XW'(k >> 1);
            bus.res_y     <= ly - YW'(k >> 1);
            bus.res_valid <= 1'b1;
            if (last) begin
              bus.frame_done <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              bus.pix_ready <= 1'b1;
              state         <= ST_FILL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
